pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

- Central pipeline control block for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). It sits between the decode and execute stages.
- It combines three conditions into one consistent set of pipeline-register write-enables and flush/bubble controls:
  - load-use hazards,
  - taken-branch flushes,
  - multi-cycle multiply/divide occupancy of EX.
- A small FSM with a down-counter sequences the multi-cycle EX hold. All other decisions are same-cycle combinational.

## Interface
Parameters:
- MD_CYCLES, 4, total cycles a mul/div instruction occupies EX (legal range 1..16).
- CNT_W, 4, width of the internal occupancy counter; must hold MD_CYCLES-2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- if_id_rs1  in  5  rs1 of the instruction in ID.
- if_id_rs2  in  5  rs2 of the instruction in ID.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_md_start  in  1  mul/div instruction has entered EX this cycle.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID register load enable.
- id_ex_write  out  1  ID/EX register load enable.
- if_id_flush  out  1  zero IF/ID on next edge.
- id_ex_flush  out  1  load NOP into ID/EX on next edge.
- ex_mem_bubble  out  1  load NOP into EX/MEM on next edge.
- md_busy  out  1  registered; high while FSM is in MD_WAIT.
- stall_count  out  32  count of cycles with pc_write=0.

## Operation
- FSM states: RUN, MD_WAIT. Reset state is RUN, counter 0.
- **Load-use hazard** (lu): id_ex_memread && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2).
- **RUN, priority high to low:**
  1. ex_branch_taken: pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=1, id_ex_flush=1. lu and ex_md_start are ignored.
  2. ex_md_start with MD_CYCLES>=2:
     - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
     - Next state MD_WAIT; cnt<=MD_CYCLES-2. lu is ignored.
  3. lu: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1. This is a one-cycle bubble.
  4. Otherwise all write-enables are 1 and all flush/bubble outputs are 0.
- **MD_WAIT:**
  - cnt!=0: all write-enables 0, ex_mem_bubble=1, cnt decrements. ex_branch_taken, ex_md_start and lu are ignored.
  - cnt==0: outputs identical to RUN evaluation (2) excluded, so lu is honoured. Next state RUN.
- If MD_CYCLES==1, ex_md_start is ignored and the FSM never leaves RUN.
- md_busy = (state==MD_WAIT), registered.

## Timing
- Control outputs are combinational from the current state and inputs, so they take effect at the next clk edge.
- A mul/div starting in cycle t produces:
  - EX/MEM bubbles in cycles t..t+MD_CYCLES-2,
  - result passed to EX/MEM in cycle t+MD_CYCLES-1,
  - PC/IF/ID/ID-EX frozen for MD_CYCLES-1 cycles.
- Load-use costs exactly 1 cycle. It re-evaluates each cycle, so forwarding resolves the second cycle.
- **Reset values:** while rst=1, state=RUN, cnt=0, md_busy=0, pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_bubble=1, stall_count=0.
- **Reset mid-MD_WAIT:** the FSM aborts to RUN on that edge, and the counter clears.
- Simultaneous ex_branch_taken and ex_md_start is never produced by decode. If it occurs, the branch wins.

## Configuration
- Macro: PIPE_STALL_CNT_EN.
- **Defined:** stall_count increments by 1 every cycle with rst=0 and pc_write=0, wrapping 0xFFFFFFFF→0.
- **Undefined:** no counter register is built and stall_count is tied to 0.

## Test plan
- **Load-use:** id_ex_memread=1, id_ex_rd=5, if_id_rs2=5.
  - Required: one cycle of pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next cycle, with memread=0: all enables 1.
- **rd=x0:** id_ex_memread=1, id_ex_rd=0, if_id_rs1=0 → no stall.
- **Branch priority:** ex_branch_taken=1 together with lu true.
  - Required: if_id_flush=1, id_ex_flush=1, pc_write=1, no stall.
- **Mul/div, MD_CYCLES=4:** ex_md_start pulse at cycle 0.
  - Required: ex_mem_bubble=1 in cycles 0–2, md_busy=1 in cycles 1–3, enables 0 in cycles 0–2, RUN in cycle 4.
  - A branch asserted in cycle 1 is ignored.
- **Reset mid-operation:** rst=1 in cycle 2 of a divide.
  - Required: md_busy=0 and state RUN after the edge, then stall_count=0.
- **Counter (PIPE_STALL_CNT_EN defined):** one load-use stall plus one 4-cycle divide.
  - Required: stall_count=4.
  - With the macro undefined: stall_count remains 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central pipeline control for the 5-stage RISC-V core. It merges three
//   hazard sources into one consistent set of pipeline-register enables and
//   flush/bubble controls:
//     - load-use hazards,
//     - taken-branch flushes,
//     - multi-cycle mul/div occupancy of EX.
//   A two-state FSM (RUN / MD_WAIT) with a down-counter sequences the
//   mul/div hold. Everything else is decided combinationally in the same
//   cycle.
//
// Optional feature macro: PIPE_STALL_CNT_EN
//   defined   : stall_count counts cycles with pc_write=0 (wraps at 2^32).
//   undefined : no counter register; stall_count is tied to 0.
//
// Parameters
//   MD_CYCLES : total EX occupancy of a mul/div instruction (1..16).
//   CNT_W     : occupancy counter width; must hold MD_CYCLES-2.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   id_ex_memread   : instruction in EX is a load
//   id_ex_rd        : destination register of the instruction in EX
//   if_id_rs1/rs2   : source registers of the instruction in ID
//   ex_branch_taken : branch/jump in EX resolved taken
//   ex_md_start     : mul/div instruction entered EX this cycle
//   pc_write, if_id_write, id_ex_write       : register load enables
//   if_id_flush, id_ex_flush, ex_mem_bubble  : flush / NOP-insert controls
//   md_busy         : high while the FSM is in MD_WAIT
//   stall_count     : number of cycles with pc_write=0
module pipeline_stall_controller #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // A single-cycle mul/div needs no hold, so the start pulse is ignored.
  localparam bit MD_EN   = (MD_CYCLES >= 2);
  localparam int MD_LOAD = MD_EN ? (MD_CYCLES - 2) : 0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  // x0 is never a real dependency, so a load to x0 never stalls.
  assign lu = id_ex_memread && (id_ex_rd != 5'd0) &&
              ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (rst) begin
      // Hold the pipe frozen and filled with NOPs while in reset.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
      state_d       = RUN;
      cnt_d         = '0;
    end else if (state_q == MD_WAIT && cnt_q != '0) begin
      // Mul/div still occupying EX: freeze everything upstream and keep
      // feeding NOPs into EX/MEM. All other requests wait.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
      cnt_d         = cnt_q - CNT_W'(1);
    end else begin
      // RUN, or the last MD_WAIT cycle (result leaves EX this cycle). The
      // last MD_WAIT cycle behaves like RUN without accepting a new start.
      if (state_q == MD_WAIT) begin
        state_d = RUN;
      end
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (MD_EN && state_q == RUN && ex_md_start) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
        state_d       = MD_WAIT;
        cnt_d         = CNT_W'(MD_LOAD);
      end else if (lu) begin
        // One-cycle bubble: hold PC and IF/ID, insert NOP into ID/EX.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // state_q is a flop, so md_busy is a registered output.
  assign md_busy = (state_q == MD_WAIT);

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_write) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        pc_write, if_id_write, id_ex_write;
  logic        if_id_flush, id_ex_flush, ex_mem_bubble;
  logic        md_busy;
  logic [31:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycles of mul/div occupancy still to come after the
  // current one (0 = EX free), and the expected stall counter.
  int          m_left = 0;
  logic [31:0] m_cnt  = 32'd0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MD_CYCLES(MD), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_bubble   (ex_mem_bubble),
    .md_busy         (md_busy),
    .stall_count     (stall_count)
  );

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance the model across the rising edge.
  // Control vector order: {pc_write, if_id_write, id_ex_write,
  //                        if_id_flush, id_ex_flush, ex_mem_bubble}
  task automatic step(input string tag, input logic r, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br, input logic md);
    logic [5:0] exp_ctrl;
    logic [5:0] got_ctrl;
    logic       hazard;
    logic       start_ok;
    logic       exp_busy;
    rst = r; id_ex_memread = mr; id_ex_rd = rd;
    if_id_rs1 = rs1; if_id_rs2 = rs2; ex_branch_taken = br; ex_md_start = md;
    @(negedge clk);
    hazard   = mr && rd != 0 && (rd == rs1 || rd == rs2);
    start_ok = 1'b0;
    if (r)                 exp_ctrl = 6'b000_111;
    else if (m_left > 1)   exp_ctrl = 6'b000_001;
    else if (br)           exp_ctrl = 6'b111_110;
    else if (m_left == 0 && md && MD >= 2) begin
      exp_ctrl = 6'b000_001;
      start_ok = 1'b1;
    end
    else if (hazard)       exp_ctrl = 6'b001_010;
    else                   exp_ctrl = 6'b111_000;
    exp_busy = (m_left > 0);
    got_ctrl = {pc_write, if_id_write, id_ex_write,
                if_id_flush, id_ex_flush, ex_mem_bubble};
    $display("%s: rst=%0b mr=%0b rd=%0d rs1=%0d rs2=%0d br=%0b md=%0b -> ctrl=%b busy=%0b cnt=%0d",
             tag, r, mr, rd, rs1, rs2, br, md, got_ctrl, md_busy, stall_count);
    n_cmp++;
    assert (got_ctrl === exp_ctrl) else begin
      n_bad++;
      $error("FAIL %s ctrl: got %b expected %b", tag, got_ctrl, exp_ctrl);
    end
    n_cmp++;
    assert (md_busy === exp_busy) else begin
      n_bad++;
      $error("FAIL %s md_busy: got %b expected %b", tag, md_busy, exp_busy);
    end
    n_cmp++;
    assert (stall_count === m_cnt) else begin
      n_bad++;
      $error("FAIL %s stall_count: got %0d expected %0d", tag, stall_count, m_cnt);
    end
    @(posedge clk);
    if (r) begin
      m_left = 0;
      m_cnt  = 32'd0;
    end else begin
`ifdef PIPE_STALL_CNT_EN
      if (exp_ctrl[5] == 1'b0) m_cnt = m_cnt + 32'd1;
`endif
      if (m_left > 0)    m_left = m_left - 1;
      else if (start_ok) m_left = MD - 1;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_total;
    rst = 1'b1; id_ex_memread = 1'b0; id_ex_rd = '0; if_id_rs1 = '0;
    if_id_rs2 = '0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
    @(posedge clk); #1;

    // Reset state (reset held, with a hazard present that must be masked).
    step("reset", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    idle("idle0");

    // Load-use through rs2, then cleared next cycle.
    step("lu_rs2", 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
    step("lu_clear", 1'b0, 1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
    // Load to x0 never stalls.
    step("lu_x0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    // Branch beats a simultaneous load-use hazard.
    step("br_vs_lu", 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0);

    // Mul/div: start in cycle 0, branch in cycle 1 ignored, RUN by cycle 4.
    step("md_c0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step("md_c1_br", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step("md_c2_lu", 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    step("md_c3", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle("md_c4");
    // Load-use honoured on the final MD_WAIT cycle.
    step("md2_c0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle("md2_c1");
    idle("md2_c2");
    step("md2_c3_lu", 1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0);
    idle("md2_c4");

    // Reset in cycle 2 of a divide.
    step("rdiv_c0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle("rdiv_c1");
    step("rdiv_c2_rst", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle("rdiv_after");

    // Stall counter: one load-use plus one 4-cycle divide.
    step("cnt_rst", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("cnt_lu", 1'b0, 1'b1, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0);
    step("cnt_md", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle("cnt_w1");
    idle("cnt_w2");
    idle("cnt_w3");
    @(negedge clk);
`ifdef PIPE_STALL_CNT_EN
    exp_total = 32'd4;
`else
    exp_total = 32'd0;
`endif
    n_cmp++;
    assert (stall_count === exp_total) else begin
      n_bad++;
      $error("FAIL cnt_total: got %0d expected %0d", stall_count, exp_total);
    end
    @(posedge clk); #1;

    // Randomized traffic, small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
